pll_clk_gen: RTL and testbench

Digital clock-generation block standing in for the vendor PLL: from one reference clock it produces five divided, phase-offset clocks with 50% duty and a sticky lock indicator. It sits at the top of the clock tree and feeds fabric logic. The vendor global set/reset cell is instantiated separately at top level, tied inactive, and has no connection to this block; only `pll_rst` resets it.

---
 rtl/pll_clk_gen.sv | 190 +++++++++++++++++++
 tb/tb_pll_clk_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pll_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : pll_clk_gen
// Purpose  : Digital stand-in for a vendor PLL. From the reference clock
//            clkin1 it derives five divided, phase-offset clocks with 50%
//            duty, and a sticky lock indicator.
// Ports    : clkin1   in  - reference clock (only clock of the block)
//            pll_rst  in  - asynchronous active-high reset
//            clkout0..clkout4 out - generated clocks (period ODIVn*Tclkin1)
//            pll_lock out - high once LOCK_CYCLES edges elapsed after reset
// Option   : PLL_CLK_LOCK_GATE_EN - when defined, every output is held low
//            until pll_lock and released without a truncated first pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pll_clk_gen #(
  parameter real CLKIN_FREQ  = 50.0,  // MHz, informational only
  parameter int  ODIV0       = 1,
  parameter int  ODIV1       = 2,
  parameter int  ODIV2       = 4,
  parameter int  ODIV3       = 5,
  parameter int  ODIV4       = 10,
  parameter int  PHASE0      = 0,
  parameter int  PHASE1      = 0,
  parameter int  PHASE2      = 0,
  parameter int  PHASE3      = 0,
  parameter int  PHASE4      = 0,
  parameter int  LOCK_CYCLES = 256
) (
  input  logic clkin1,
  input  logic pll_rst,
  output logic clkout0,
  output logic clkout1,
  output logic clkout2,
  output logic clkout3,
  output logic clkout4,
  output logic pll_lock
);

  localparam int          NOUT          = 5;
  localparam int          ODIV_A  [NOUT] = '{ODIV0, ODIV1, ODIV2, ODIV3, ODIV4};
  localparam int          PHASE_A [NOUT] = '{PHASE0, PHASE1, PHASE2, PHASE3, PHASE4};
  localparam logic [15:0] LOCK_TGT      = 16'(LOCK_CYCLES);

  // The reference frequency only documents the intended operating point.
  if (CLKIN_FREQ <= 0.0) begin : g_freq_info
  end

  // --------------------------------------------------------------------------
  // Reset synchronizer: asserts with pll_rst, releases two clkin1 edges later.
  // --------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rst_i;

  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign rst_i = sync_q[1];

  // --------------------------------------------------------------------------
  // Lock counter: saturates at LOCK_CYCLES; lock is set on the edge the
  // counter arrives there and is only cleared by reset.
  // --------------------------------------------------------------------------
  logic [15:0] lock_cnt_q;
  logic [15:0] lock_cnt_d;
  logic        lock_q;
  logic        lock_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (lock_cnt_q != LOCK_TGT) begin
      lock_cnt_d = lock_cnt_q + 16'd1;
    end
    lock_d = lock_q | (lock_cnt_d == LOCK_TGT);
  end

  always_ff @(posedge clkin1 or posedge rst_i) begin
    if (rst_i) begin
      lock_cnt_q <= 16'd0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign pll_lock = lock_q;

  // --------------------------------------------------------------------------
  // Output dividers
  // --------------------------------------------------------------------------
  logic [NOUT-1:0] clk_out;

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    localparam int D = ODIV_A[k];
    localparam int P = PHASE_A[k];

    logic raw;     // ungated divider output
    logic gate_q;  // falling-edge enable so it never cuts a high phase
    logic gate_d;
`ifdef PLL_CLK_LOCK_GATE_EN
    logic busy;    // divider high phase in progress at this falling edge
`endif

    if (D == 1) begin : g_bypass
      assign raw = clkin1;
`ifdef PLL_CLK_LOCK_GATE_EN
      // clkin1 is low right after its falling edge, so opening is always safe
      assign busy = 1'b0;
`endif
    end else begin : g_div
      localparam logic [9:0] LAST = 10'(D - 1);
      // Preloading with (D-P) mod D delays the counter sequence by P cycles.
      localparam logic [9:0] LOAD = 10'((D - P) % D);
      // (D+1)/2 equals D/2 for even D, so one threshold serves both cases.
      localparam logic [9:0] HIGH = 10'((D + 1) / 2);

      logic [9:0] cnt_q;
      logic [9:0] cnt_d;
      logic       p_q;
      logic       p_d;

      always_comb begin
        cnt_d = (cnt_q == LAST) ? 10'd0 : cnt_q + 10'd1;
        p_d   = (cnt_q < HIGH);
      end

      always_ff @(posedge clkin1 or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= LOAD;
          p_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          p_q   <= p_d;
        end
      end

`ifdef PLL_CLK_LOCK_GATE_EN
      assign busy = p_q;
`endif

      if ((D % 2) == 0) begin : g_even
        assign raw = p_q;
      end else begin : g_odd
        // The falling-edge copy trims half a cycle off the (D+1)/2 high
        // phase, giving exactly D/2 input periods high.
        logic n_q;

        always_ff @(negedge clkin1 or posedge rst_i) begin
          if (rst_i) begin
            n_q <= 1'b0;
          end else begin
            n_q <= p_q;
          end
        end

        assign raw = p_q & n_q;
      end
    end

`ifdef PLL_CLK_LOCK_GATE_EN
    // Opens only while the divider is low, so the first pulse is full width.
    assign gate_d = lock_q & (gate_q | ~busy);
`else
    assign gate_d = 1'b1;
`endif

    always_ff @(negedge clkin1 or posedge rst_i) begin
      if (rst_i) begin
        gate_q <= 1'b0;
      end else begin
        gate_q <= gate_d;
      end
    end

    assign clk_out[k] = raw & gate_q;
  end

  assign clkout0 = clk_out[0];
  assign clkout1 = clk_out[1];
  assign clkout2 = clk_out[2];
  assign clkout3 = clk_out[3];
  assign clkout4 = clk_out[4];

endmodule
`default_nettype wire

// File: tb/tb_pll_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_clk_gen
// Purpose  : Self-checking bench for pll_clk_gen. Random reset pulses and run
//            lengths; expected output levels are derived per half cycle from
//            the divide/phase/lock rules and compared through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_clk_gen;

  localparam int L        = 20;
  localparam int D [5]    = '{1, 4, 4, 5, 10};
  localparam int P [5]    = '{0, 0, 1, 3, 7};

  logic       clkin1 = 1'b0;
  logic       pll_rst = 1'b0;
  logic [4:0] clkout;
  logic       pll_lock;

  always #10 clkin1 = ~clkin1;

  pll_clk_gen #(
    .CLKIN_FREQ (50.0),
    .ODIV0 (D[0]), .ODIV1 (D[1]), .ODIV2 (D[2]), .ODIV3 (D[3]), .ODIV4 (D[4]),
    .PHASE0(P[0]), .PHASE1(P[1]), .PHASE2(P[2]), .PHASE3(P[3]), .PHASE4(P[4]),
    .LOCK_CYCLES(L)
  ) dut (
    .clkin1  (clkin1),
    .pll_rst (pll_rst),
    .clkout0 (clkout[0]),
    .clkout1 (clkout[1]),
    .clkout2 (clkout[2]),
    .clkout3 (clkout[3]),
    .clkout4 (clkout[4]),
    .pll_lock(pll_lock)
  );

  typedef struct packed {
    logic [5:0] exp;
    logic [5:0] care;
    int         n;
    int         half;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   nprint  = 0;
  int   n_edges = 0;   // rising edges since pll_rst was released
  bit   running = 1'b1;

  // Reference: edge n after release; synchronizer costs edges 1 and 2, the
  // dividers run from edge 3 (m = 0). Position in the output period is
  // (m - PHASE) mod ODIV; h counts half cycles into that period.
  function automatic logic [5:0] model(input int n, input int half);
    logic [5:0] e;
    e = '0;
    if (n >= 3) begin
      for (int k = 0; k < 5; k++) begin
        int m;
        int j;
        int h;
        m = n - 3;
        j = (((m - P[k]) % D[k]) + D[k]) % D[k];
        h = 2 * j + half;
        if (D[k] == 1 || (D[k] % 2) == 0) e[k] = (h < D[k]);
        else                              e[k] = (h >= 1 && h <= D[k]);
      end
    end
    e[5] = (n >= L + 2);
`ifdef PLL_CLK_LOCK_GATE_EN
    if (n < L + 2) e[4:0] = '0;
`endif
    return e;
  endfunction

  function automatic logic [5:0] care_mask(input int n, input int half);
    logic [5:0] c;
    c = '1;
    // Odd dividers start with their falling-edge half cleared from reset.
    for (int k = 0; k < 5; k++) begin
      if (n == 3 && half == 0 && D[k] > 1 && (D[k] % 2) == 1) c[k] = 1'b0;
    end
`ifdef PLL_CLK_LOCK_GATE_EN
    if (n >= L + 2 && n < L + 2 + 2 * 10) c = 6'b100000;
`endif
    return c;
  endfunction

  task automatic push(input int half);
    exp_t e;
    int   n;
    n      = pll_rst ? 0 : n_edges;
    e.n    = n;
    e.half = half;
    e.exp  = model(n, half);
    e.care = care_mask(n, half);
    q.push_back(e);
  endtask

  // Expected-value generator
  always @(posedge clkin1) begin
    if (pll_rst) n_edges = 0;
    else         n_edges = n_edges + 1;
    #1 push(0);
  end

  always @(negedge clkin1) begin
    #1 push(1);
  end

  // Monitor: samples every half cycle and compares against the queue head
  exp_t       got;
  logic [5:0] act;

  always @(clkin1) begin
    #2;
    if (running) begin
      act    = {pll_lock, clkout};
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        if (nprint < 20) $display("FAIL scoreboard_empty t=%0t actual=%b", $time, act);
        nprint = nprint + 1;
      end else begin
        got = q.pop_front();
        if (((act ^ got.exp) & got.care) !== 6'b0) begin
          errors = errors + 1;
          if (nprint < 20)
            $display("FAIL sample n=%0d half=%0d t=%0t actual(lock,out)=%b required=%b care=%b",
                     got.n, got.half, $time, act, got.exp, got.care);
          nprint = nprint + 1;
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks = checks + 1;
    if ({pll_lock, clkout} !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t actual(lock,out)=%b required=000000", name, $time, {pll_lock, clkout});
    end
  endtask

  initial begin
    pll_rst = 1'b0;
    #1 pll_rst = 1'b1;
    #1 check_zero("reset_initial");
    for (int r = 0; r < 8; r++) begin
      int hold;
      int run;
      hold = $urandom_range(2, 3);
      run  = (r == 0 || r == 4) ? L + 40 : $urandom_range(3, L + 30);
      repeat (hold) @(posedge clkin1);
      @(negedge clkin1);
      #5 pll_rst = 1'b0;
      repeat (run) @(posedge clkin1);
      // Asynchronous assertion mid-cycle: no clock edge before the check.
      #($urandom_range(4, 7)) pll_rst = 1'b1;
      #1 check_zero("reset_async");
    end
    repeat (3) @(posedge clkin1);
    @(negedge clkin1);
    #5 pll_rst = 1'b0;
    repeat (L + 30) @(posedge clkin1);
    #4 running = 1'b0;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
